// File: rtl/fir_tap_accumulator_if.sv
// Stream bus of the FIR tap accumulator: product input, sample output, and partial-sum status.
interface fir_tap_accumulator_if #(
  parameter int unsigned DW = 32
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          approx_en;
  logic          flush;
  logic [DW-1:0] out_data;
  logic          out_ovf;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    tap_cnt;

  modport master (
    output in_data, in_valid, approx_en, flush, out_ready,
    input  in_ready, out_data, out_ovf, out_valid, tap_cnt
  );

  modport slave (
    input  in_data, in_valid, approx_en, flush, out_ready,
    output in_ready, out_data, out_ovf, out_valid, tap_cnt
  );
endinterface

// File: rtl/fir_tap_accumulator.sv
// Sums NTAPS tap products per output sample with a run-time exact or lower-part-OR adder,
// holding the result in a one-entry output register with valid/ready backpressure.
module fir_tap_accumulator #(
  parameter int unsigned DW         = 32,
  parameter int unsigned NTAPS      = 8,
  parameter int unsigned APPROX_LSB = 10
) (
  input logic                 clk,
  input logic                 rst,
  fir_tap_accumulator_if.slave bus
);
  localparam int unsigned L   = APPROX_LSB;
  localparam int unsigned UW  = DW - L;
  localparam int unsigned UW1 = UW + 1;
  localparam int unsigned DW1 = DW + 1;

  typedef enum logic {ACCUM, LAST} phase_e;

  phase_e        phase_q;
  logic [DW-1:0] acc_q;
  logic          ovf_acc_q;
  logic [7:0]    tap_cnt_q;
  logic [DW-1:0] out_data_q;
  logic          out_ovf_q;
  logic          out_valid_q;

  logic [DW:0]   exact_sum;
  logic [UW:0]   upper_sum;
  logic          carry_l;
  logic [DW-1:0] add_sum;
  logic          add_carry;
  logic          in_ready_c;
  logic          accept;
  logic          handshake;

  // Approximate mode ORs the low L bits and feeds a single guessed carry into the exact upper add.
  always_comb begin
    exact_sum = DW1'({1'b0, acc_q}) + DW1'({1'b0, bus.in_data});
    carry_l   = acc_q[L-1] & bus.in_data[L-1];
    upper_sum = UW1'({1'b0, acc_q[DW-1:L]}) + UW1'({1'b0, bus.in_data[DW-1:L]}) + UW1'(carry_l);
    if (bus.approx_en) begin
      add_sum   = {upper_sum[UW-1:0], acc_q[L-1:0] | bus.in_data[L-1:0]};
      add_carry = upper_sum[UW];
    end else begin
      add_sum   = exact_sum[DW-1:0];
      add_carry = exact_sum[DW];
    end
  end

  // Only the final product stalls, and only while the previous sample is still unread.
  assign in_ready_c = ~((phase_q == LAST) & out_valid_q & ~bus.out_ready);
  assign accept     = bus.in_valid & in_ready_c & ~bus.flush;
  assign handshake  = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= ACCUM;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      tap_cnt_q   <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept && (phase_q == LAST)) begin
        out_data_q  <= add_sum;
        out_ovf_q   <= ovf_acc_q | add_carry;
        out_valid_q <= 1'b1;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end

      if (bus.flush) begin
        phase_q   <= ACCUM;
        acc_q     <= '0;
        ovf_acc_q <= 1'b0;
        tap_cnt_q <= '0;
      end else if (accept) begin
        case (phase_q)
          ACCUM: begin
            acc_q     <= add_sum;
            ovf_acc_q <= ovf_acc_q | add_carry;
            tap_cnt_q <= tap_cnt_q + 8'd1;
            if (tap_cnt_q == 8'(NTAPS - 2)) phase_q <= LAST;
          end
          LAST: begin
            phase_q   <= ACCUM;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            tap_cnt_q <= '0;
          end
          default: phase_q <= ACCUM;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_valid = out_valid_q;
  assign bus.tap_cnt   = tap_cnt_q;
endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Self-checking bench for fir_tap_accumulator: directed scenarios plus a randomized run against
// a sample-level arithmetic reference model.
module tb_fir_tap_accumulator;
  localparam int unsigned DW = 32;
  localparam int unsigned NT = 4;
  localparam int unsigned L  = 10;

  logic clk;
  logic rst;
  fir_tap_accumulator_if #(.DW(DW)) bus ();

  fir_tap_accumulator #(.DW(DW), .NTAPS(NT), .APPROX_LSB(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: partial sum plus the pending output register.
  logic [31:0] m_acc;
  bit          m_ovf;
  int          m_cnt;
  bit          m_ov;
  logic [31:0] m_od;
  bit          m_oo;

  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input bit ax);
    logic [63:0] la, lb, lo, up, s;
    la = 64'(a);
    lb = 64'(b);
    if (!ax) s = la + lb;
    else begin
      lo = (la | lb) % (64'd1 << L);
      up = (la >> L) + (lb >> L) + (((la >> (L - 1)) & (lb >> (L - 1))) & 64'd1);
      s  = (up << L) + lo;
    end
    return {s[32], s[31:0]};
  endfunction

  function automatic bit model_rdy(input bit ordy);
    return !((m_cnt == NT - 1) && m_ov && !ordy);
  endfunction

  task automatic model_reset();
    m_acc = '0; m_ovf = 0; m_cnt = 0; m_ov = 0; m_od = '0; m_oo = 0;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit ax, input bit fl, input bit ordy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.approx_en = ax;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
  endtask

  // Advance the model by one clock using the currently driven inputs, then take the edge.
  task automatic tick();
    bit acc, hs, fin;
    logic [32:0] r;
    acc = bus.in_valid && model_rdy(bus.out_ready) && !bus.flush;
    hs  = m_ov && bus.out_ready;
    fin = acc && (m_cnt == NT - 1);
    r   = ref_add(m_acc, bus.in_data, bus.approx_en);
    if (fin) begin
      m_od = r[31:0]; m_oo = m_ovf | r[32]; m_ov = 1;
    end else if (hs) m_ov = 0;
    if (bus.flush || fin) begin
      m_acc = '0; m_ovf = 0; m_cnt = 0;
    end else if (acc) begin
      m_acc = r[31:0]; m_ovf = m_ovf | r[32]; m_cnt++;
    end
    @(posedge clk);
  endtask

  task automatic run_sample(input logic [31:0] d [4], input bit ax);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d[i], ax, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 0; bus.in_data = '0; bus.approx_en = 0; bus.flush = 0; bus.out_ready = 1;
    model_reset();
    #12;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    n_vec++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf got %b want 0", bus.out_ovf); end
    n_vec++; if (bus.tap_cnt !== 8'd0) begin n_err++; $display("FAIL reset_tap_cnt got %0d want 0", bus.tap_cnt); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_exact();
    run_sample('{32'd1, 32'd2, 32'd3, 32'd4}, 1'b0);
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL exact_valid got %b want 1", bus.out_valid); end
    n_vec++; if (bus.out_data !== 32'd10) begin n_err++; $display("FAIL exact_data got %0d want 10", bus.out_data); end
    n_vec++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL exact_ovf got %b want 0", bus.out_ovf); end
    n_vec++; if (bus.tap_cnt !== 8'd0) begin n_err++; $display("FAIL exact_tap_cnt got %0d want 0", bus.tap_cnt); end
    tick();
  endtask

  task automatic test_wrap();
    run_sample('{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0}, 1'b0);
    n_vec++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL wrap_data got %h want 0", bus.out_data); end
    n_vec++; if (bus.out_ovf !== 1'b1) begin n_err++; $display("FAIL wrap_ovf got %b want 1", bus.out_ovf); end
    tick();
    run_sample('{32'd1, 32'd1, 32'd1, 32'd1}, 1'b0);
    n_vec++; if (bus.out_data !== 32'd4) begin n_err++; $display("FAIL wrap_next_data got %0d want 4", bus.out_data); end
    n_vec++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL wrap_next_ovf got %b want 0", bus.out_ovf); end
    tick();
  endtask

  task automatic test_approx();
    run_sample('{32'h3, 32'h3, 32'h400, 32'h200}, 1'b1);
    n_vec++; if (bus.out_data !== 32'h603) begin n_err++; $display("FAIL approx_data got %h want 603", bus.out_data); end
    tick();
    run_sample('{32'h3, 32'h3, 32'h400, 32'h200}, 1'b0);
    n_vec++; if (bus.out_data !== 32'h606) begin n_err++; $display("FAIL approx_off_data got %h want 606", bus.out_data); end
    tick();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 32'd1, 1'b0, 1'b0, 1'b0); tick(); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_nonfinal_ready got %b want 1", bus.in_ready); end
      tick();
    end
    drive(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready got %b want 0", bus.in_ready); end
    n_vec++; if (bus.out_data !== 32'd4) begin n_err++; $display("FAIL bp_hold_data got %0d want 4", bus.out_data); end
    tick();
    drive(1'b1, 32'd2, 1'b0, 1'b0, 1'b1);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
    n_vec++; if (bus.tap_cnt !== 8'd3) begin n_err++; $display("FAIL bp_tap_cnt got %0d want 3", bus.tap_cnt); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_no_bubble got %b want 1", bus.out_valid); end
    n_vec++; if (bus.out_data !== 32'd8) begin n_err++; $display("FAIL bp_b_data got %0d want 8", bus.out_data); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'd5, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 32'd6, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 32'd7, 1'b0, 1'b1, 1'b1);
    n_vec++; if (bus.tap_cnt !== 8'd2) begin n_err++; $display("FAIL flush_pre_cnt got %0d want 2", bus.tap_cnt); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_vec++; if (bus.tap_cnt !== 8'd0) begin n_err++; $display("FAIL flush_cnt got %0d want 0", bus.tap_cnt); end
    tick();
    run_sample('{32'd1, 32'd1, 32'd1, 32'd1}, 1'b0);
    n_vec++; if (bus.out_data !== 32'd4) begin n_err++; $display("FAIL flush_data got %0d want 4", bus.out_data); end
    tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) begin drive(1'b1, 32'd1, 1'b0, 1'b0, 1'b0); tick(); end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.tap_cnt !== 8'd3) begin n_err++; $display("FAIL ar_pre_cnt got %0d want 3", bus.tap_cnt); end
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre_valid got %b want 1", bus.out_valid); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL ar_data got %h want 0", bus.out_data); end
    n_vec++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL ar_ovf got %b want 0", bus.out_ovf); end
    n_vec++; if (bus.tap_cnt !== 8'd0) begin n_err++; $display("FAIL ar_cnt got %0d want 0", bus.tap_cnt); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL ar_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
      n_vec++; if (bus.in_ready !== model_rdy(bus.out_ready)) begin n_err++;
        $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, bus.in_ready, model_rdy(bus.out_ready)); end
      n_vec++; if (bus.out_valid !== m_ov) begin n_err++;
        $display("FAIL rnd_out_valid cyc %0d got %b want %b", c, bus.out_valid, m_ov); end
      n_vec++; if (bus.tap_cnt !== 8'(m_cnt)) begin n_err++;
        $display("FAIL rnd_tap_cnt cyc %0d got %0d want %0d", c, bus.tap_cnt, m_cnt); end
      if (m_ov) begin
        n_vec++; if (bus.out_data !== m_od || bus.out_ovf !== m_oo) begin n_err++;
          $display("FAIL rnd_out cyc %0d got %h/%b want %h/%b", c, bus.out_data, bus.out_ovf, m_od, m_oo); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_wrap();
    test_approx();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fir_tap_accumulator.md
Name: fir_tap_accumulator

Overview:
- Streaming accumulation stage directly downstream of the FIR product adder.
- Consumes one 32-bit tap product per handshake and sums NTAPS products into one filter output sample.
- Summation uses either an exact add or a lower-part-OR approximate add, selected at run time.
- Delivers each sample through a one-entry output register with valid/ready backpressure, and flags wrap-around overflow.

Parameters:
- DW, 32, data width of products, accumulator and result.
- NTAPS, 8, products per output sample; legal range 2..256.
- APPROX_LSB, 10, number of low bits approximated when approx_en=1; legal range 1..DW-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DW  tap product, unsigned.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- approx_en  input  1  1 selects the approximate add for the product accepted this cycle.
- flush  input  1  synchronous discard of the partial sum.
- out_data  output  DW  completed sample.
- out_ovf  output  1  at least one carry out of bit DW-1 occurred while this sample was summed.
- out_valid  output  1  out_data/out_ovf valid.
- out_ready  input  1  downstream accepts the output.
- tap_cnt  output  8  number of products accumulated into the current partial sum.

Behaviour:
- Reset (async, rst=1):
  - acc=0, tap_cnt=0, ovf_acc=0.
  - out_data=0, out_ovf=0, out_valid=0.
  - in_ready=1 combinationally once the reset is released.
- Accept: accept = in_valid & in_ready & ~flush.
- Add: sum = acc + in_data, modulo 2^DW; carry c is the bit out of DW-1.
  - approx_en=0: exact binary add.
  - approx_en=1, with L=APPROX_LSB:
    - sum[L-1:0] = acc[L-1:0] | in_data[L-1:0].
    - Carry into bit L = acc[L-1] & in_data[L-1].
    - Bits L..DW-1 are an exact ripple add of the upper operand bits plus that carry; c is the carry out of DW-1.
- Non-final accept (tap_cnt < NTAPS-1): acc<=sum, ovf_acc<=ovf_acc|c, tap_cnt<=tap_cnt+1.
- Final accept (tap_cnt == NTAPS-1):
  - Next cycle: out_data=sum, out_ovf=ovf_acc|c, out_valid=1.
  - acc<=0, ovf_acc<=0, tap_cnt<=0.
  - Latency: 1 cycle from final accept to out_valid.
- in_ready = ~(tap_cnt==NTAPS-1 & out_valid & ~out_ready).
  - Only the final product of a sample is ever stalled; non-final products always accept.
- Output handshake:
  - out_valid stays 1, and out_data/out_ovf stay stable, until out_valid & out_ready.
  - Handshake with no final accept in the same cycle: out_valid<=0.
  - Handshake and final accept in the same cycle: new result loaded, out_valid stays 1, no bubble.
- Flush:
  - Wins over a coincident in_valid; that product is dropped.
  - Next cycle: acc=0, tap_cnt=0, ovf_acc=0.
  - A pending output register is unaffected.
- approx_en may change between products of one sample; each add uses the value present on its own accept cycle.
- Reset mid-sample: partial sum and pending output are lost, with no output emitted.
- Two FSM phases:
  - ACCUM: tap_cnt < NTAPS-1.
  - LAST: tap_cnt == NTAPS-1; in_ready may drop.
  - Transitions: ACCUM->LAST on accept at tap_cnt=NTAPS-2; LAST->ACCUM on final accept or flush; any->ACCUM on flush or reset.

Test Plan:
- Exact sum, NTAPS=4, approx_en=0, out_ready=1: products 1,2,3,4 on consecutive cycles -> out_data=10 and out_ovf=0, one cycle after the 4th accept; tap_cnt returns to 0.
- Wrap and overflow, NTAPS=4: products 0xFFFFFFFF,1,0,0 -> out_data=0x00000000, out_ovf=1; the next sample 1,1,1,1 -> out_data=4, out_ovf=0 (flag cleared).
- Approximate add, NTAPS=4, APPROX_LSB=10, approx_en=1: products 0x3,0x3,0x400,0x200 -> out_data=0x603. The same stream with approx_en=0 -> 0x606.
- Backpressure: hold out_ready=0 after sample A (1,1,1,1 -> 4); stream sample B (2,2,2,2).
  - The first 3 products of B are accepted; the 4th sees in_ready=0 and out_data stays 4.
  - Raise out_ready for one cycle -> A handshakes, B's 4th product is accepted that cycle, next cycle out_data=8 with out_valid continuously 1.
- Flush: after products 5,6 (tap_cnt=2), assert flush together with in_valid (data 7) -> 7 dropped, tap_cnt=0. Then 1,1,1,1 -> out_data=4.
- Async reset: assert rst mid-cycle at tap_cnt=3 with out_valid=1 -> out_valid, out_data, out_ovf and tap_cnt go to 0 immediately, without waiting for a clock edge; in_ready=1 after release.
